ex_pipe_stage: RTL and testbench
================================

EX_PIPE_STAGE -- requirements
Module: ex_pipe_stage

Interface
- REQ-001: Parameter DATA_WIDTH, default 32, sets the operand, immediate and result width.
- REQ-002: Parameter REG_ADDR_WIDTH, default 5, sets the register-address width.
- REQ-003: Parameter LINK_REG, default 15, is the destination register selected for link writes.
- REQ-004: Parameter CTRL_WIDTH, default 8, sets the width of the opaque sideband control bundle.
- REQ-005: Ports, one per line (name, direction, width, meaning):
  - clk  in  1  single clock; all state updates on the rising edge.
  - rst  in  1  reset, asynchronous and active-low.
  - flush  in  1  kill the in-flight and held operation.
  - in_valid  in  1  upstream operation present.
  - in_ready  out  1  stage accepts an operation this cycle.
  - alu_funct  in  6  operation code.
  - alu_src_mux  in  1  operand B select: 0 = in_data_rt, 1 = in_immediate.
  - reg_dst_mux  in  2  destination select: 0 = in_rt, 1 = in_rd, 2 = LINK_REG, 3 = in_rt.
  - in_data_rs, in_data_rt, in_immediate  in  DATA_WIDTH  operands.
  - in_rt, in_rd  in  REG_ADDR_WIDTH  register addresses.
  - in_ctrl  in  CTRL_WIDTH  sideband bundle, passed through unmodified.
  - out_valid  out  1  result held for downstream.
  - out_ready  in  1  downstream consumes the result.
  - alu_out  out  DATA_WIDTH  result.
  - alu_flags_out  out  6  flags: [5] carry, [4] overflow, [3] negative, [2] zero, [1] illegal, [0] 0.
  - reg_dst  out  REG_ADDR_WIDTH  selected destination register.
  - mem_addr, mem_data  out  DATA_WIDTH  registered in_data_rs and in_data_rt.
  - out_ctrl  out  CTRL_WIDTH  registered in_ctrl.
  - busy  out  1  multiply in progress.

Function
- REQ-006: An operation is accepted on a rising edge when in_valid and in_ready are both 1.
- REQ-007: in_ready = (state == IDLE) and (out_valid == 0 or out_ready == 1) and (flush == 0).
- REQ-008: Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR.
  - 0x05 SLT (signed less-than; result 1 or 0), 0x06 PASSB (result = operand B).
  - 0x10 MUL (low DATA_WIDTH bits of the unsigned product).
  - Any other code: result 0, flag [1] set.
- REQ-009: Single-cycle operations latch the result, flags, reg_dst, mem_addr, mem_data and out_ctrl on the accepting edge, and out_valid rises on that edge.
- REQ-010: ADD carry is bit DATA_WIDTH of the (DATA_WIDTH+1)-bit sum.
- REQ-011: SUB carry is 1 when a borrow occurs (A < B unsigned).
- REQ-012: The overflow flag is signed overflow for ADD and SUB, and 0 for all other operations.
- REQ-013: The zero and negative flags are computed from the result for every operation.
- REQ-014: FSM states: IDLE and MUL.
  - IDLE -> MUL on accepting opcode 0x10.
  - MUL runs one shift-add iteration per cycle for DATA_WIDTH cycles, then returns to IDLE.
  - On the return edge: out_valid is set and the result is written.
- REQ-015: busy is 1 in state MUL; MUL latency is DATA_WIDTH + 1 edges from acceptance to out_valid.
- REQ-016: out_valid and all output data hold stable while out_valid = 1 and out_ready = 0.
- REQ-017: out_valid clears on an edge with out_ready = 1 unless a new operation is accepted on the same edge, which reloads the outputs with no bubble.
- REQ-018: flush = 1 on an edge:
  - clears out_valid;
  - aborts MUL and returns the FSM to IDLE;
  - blocks acceptance;
  - flush takes priority over all simultaneous events.
- REQ-019: For MUL, the sideband and address fields are captured at acceptance and presented together with the result.

Reset
- REQ-020: While rst is low, asynchronously:
  - state = IDLE, out_valid = 0, busy = 0;
  - all data outputs, flags and out_ctrl = 0;
  - iteration counter = 0.
- REQ-021: Reset asserted during MUL discards the operation, and no result is emitted after release.

Configuration
- REQ-022: Macro EX_PIPE_MUL_EN.
  - When defined: the MUL state and iterative multiplier are built as specified.
  - When undefined: opcode 0x10 is treated as illegal (single cycle, result 0, flag [1] = 1), busy is tied to 0, and no MUL state exists.

Verification
- REQ-023: ADD, DATA_WIDTH = 32, rs = 0xFFFFFFFF, rt = 1, out_ready = 1 -> next edge: alu_out = 0, flags [5] = 1, [2] = 1, [4] = 0.
- REQ-024: SUB, rs = 0x80000000, rt = 1 -> alu_out = 0x7FFFFFFF, overflow = 1, carry = 0.
- REQ-025: MUL 7 x 6 with EX_PIPE_MUL_EN defined -> busy = 1 for 32 cycles, in_ready = 0 throughout, out_valid rises on edge 33 with alu_out = 42; without the macro -> out_valid after 1 edge with flag [1] = 1.
- REQ-026: Backpressure: out_ready = 0 with two back-to-back ADDs -> second held off (in_ready = 0), first result stable; out_ready = 1 -> second result loaded on the same edge with no bubble.
- REQ-027: flush asserted on MUL iteration 10 -> busy = 0 and out_valid = 0 next cycle, and no result ever appears; in_ready = 1 the cycle after flush deasserts.
- REQ-028: rst low mid-MUL with reg_dst_mux = 2 pending -> all outputs 0 immediately; after release, reg_dst = 0 and out_valid stays 0.

Source files
------------

// File: rtl/ex_pipe_stage.sv
// ----------------------------------------------------------------------------
// ex_pipe_stage
//
// Execute stage of an in-order pipeline. It takes one operation per cycle
// through a valid/ready handshake, evaluates it on the ALU, and holds the
// result in an output register until downstream consumes it. Single-cycle
// operations are registered on the accepting edge. MUL, when it is built,
// runs an iterative shift-add multiplier for DATA_WIDTH cycles while the
// input side is stalled.
//
// Build option:
//   EX_PIPE_MUL_EN - When defined, this builds the MUL state and the iterative
//                    multiplier. When undefined, opcode 0x10 is decoded as an
//                    illegal single-cycle operation, and busy is tied low.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   flush             kills the held result and any multiply in progress
//   in_valid/ready    upstream handshake
//   alu_funct         operation code
//   alu_src_mux       operand B select (0: in_data_rt, 1: in_immediate)
//   reg_dst_mux       destination select (rt / rd / LINK_REG / rt)
//   in_data_rs/rt     register operands
//   in_immediate      immediate operand
//   in_rt, in_rd      register addresses
//   in_ctrl           opaque sideband, passed through
//   out_valid/ready   downstream handshake
//   alu_out           result
//   alu_flags_out     {carry, overflow, negative, zero, illegal, 0}
//   reg_dst           selected destination register
//   mem_addr/data     registered in_data_rs / in_data_rt
//   out_ctrl          registered in_ctrl
//   busy              multiply in progress
// ----------------------------------------------------------------------------
module ex_pipe_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int LINK_REG       = 15,
    parameter int CTRL_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [5:0]                alu_funct,
    input  logic                      alu_src_mux,
    input  logic [1:0]                reg_dst_mux,
    input  logic [DATA_WIDTH-1:0]     in_data_rs,
    input  logic [DATA_WIDTH-1:0]     in_data_rt,
    input  logic [DATA_WIDTH-1:0]     in_immediate,
    input  logic [REG_ADDR_WIDTH-1:0] in_rt,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [CTRL_WIDTH-1:0]     in_ctrl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     alu_out,
    output logic [5:0]                alu_flags_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_dst,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data,
    output logic [CTRL_WIDTH-1:0]     out_ctrl,
    output logic                      busy
);

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_SLT   = 6'h05;
    localparam logic [5:0] OP_PASSB = 6'h06;

    localparam int MSB = DATA_WIDTH - 1;
    localparam logic [REG_ADDR_WIDTH-1:0] LINK_ADDR = REG_ADDR_WIDTH'(LINK_REG);
    localparam logic [DATA_WIDTH-1:0]     ZERO_D    = {DATA_WIDTH{1'b0}};

    // Flag vector packing shared by the ALU and the multiplier paths.
    function automatic logic [5:0] make_flags(
        input logic                  carry,
        input logic                  ovf,
        input logic [DATA_WIDTH-1:0] res,
        input logic                  illegal
    );
        make_flags = {carry, ovf, res[MSB], (res == ZERO_D), illegal, 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Combinational operand select, ALU, and destination select
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     op_b_s;
    logic [DATA_WIDTH:0]       sum_s;
    logic [DATA_WIDTH:0]       diff_s;
    logic [DATA_WIDTH-1:0]     alu_res_s;
    logic                      alu_carry_s;
    logic                      alu_ovf_s;
    logic                      alu_illegal_s;
    logic [REG_ADDR_WIDTH-1:0] dst_sel_s;

    // Operand B mux and the single-cycle ALU. Borrow is the top bit of the
    // widened difference, so SUB carry is set exactly when rs < B unsigned.
    always_comb begin
        if (alu_src_mux) begin
            op_b_s = in_immediate;
        end else begin
            op_b_s = in_data_rt;
        end
        sum_s         = {1'b0, in_data_rs} + {1'b0, op_b_s};
        diff_s        = {1'b0, in_data_rs} - {1'b0, op_b_s};
        alu_res_s     = ZERO_D;
        alu_carry_s   = 1'b0;
        alu_ovf_s     = 1'b0;
        alu_illegal_s = 1'b0;
        case (alu_funct)
            OP_ADD: begin
                alu_res_s   = sum_s[MSB:0];
                alu_carry_s = sum_s[DATA_WIDTH];
                alu_ovf_s   = (in_data_rs[MSB] == op_b_s[MSB]) &&
                              (sum_s[MSB] != in_data_rs[MSB]);
            end
            OP_SUB: begin
                alu_res_s   = diff_s[MSB:0];
                alu_carry_s = diff_s[DATA_WIDTH];
                alu_ovf_s   = (in_data_rs[MSB] != op_b_s[MSB]) &&
                              (diff_s[MSB] != in_data_rs[MSB]);
            end
            OP_AND:   alu_res_s = in_data_rs & op_b_s;
            OP_OR:    alu_res_s = in_data_rs | op_b_s;
            OP_XOR:   alu_res_s = in_data_rs ^ op_b_s;
            OP_SLT: begin
                if ($signed(in_data_rs) < $signed(op_b_s)) begin
                    alu_res_s = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    alu_res_s = ZERO_D;
                end
            end
            OP_PASSB: alu_res_s = op_b_s;
            default:  alu_illegal_s = 1'b1;
        endcase
    end

    // Destination register select; code 3 aliases code 0.
    always_comb begin
        case (reg_dst_mux)
            2'd0:    dst_sel_s = in_rt;
            2'd1:    dst_sel_s = in_rd;
            2'd2:    dst_sel_s = LINK_ADDR;
            default: dst_sel_s = in_rt;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and sequencing
    // ------------------------------------------------------------------
    logic out_valid_r;
    logic in_ready_s;
    logic accept_s;
    logic load_alu_s;
    logic valid_nxt_s;

    assign accept_s = in_valid && in_ready_s;
    assign in_ready = in_ready_s;

`ifdef EX_PIPE_MUL_EN
    localparam logic [5:0] OP_MUL = 6'h10;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                    state_r;
    state_t                    state_nxt_s;
    logic                      is_mul_s;
    logic                      start_mul_s;
    logic                      load_mul_s;
    logic                      mul_last_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [DATA_WIDTH-1:0]     mcand_r;
    logic [DATA_WIDTH-1:0]     mplier_r;
    logic [DATA_WIDTH-1:0]     acc_r;
    logic [DATA_WIDTH-1:0]     acc_nxt_s;
    logic [REG_ADDR_WIDTH-1:0] pend_dst_r;
    logic [DATA_WIDTH-1:0]     pend_addr_r;
    logic [DATA_WIDTH-1:0]     pend_data_r;
    logic [CTRL_WIDTH-1:0]     pend_ctrl_r;

    assign is_mul_s   = (alu_funct == OP_MUL);
    assign mul_last_s = (cnt_r == CNT_LAST);
    assign busy       = (state_r == ST_MUL);
    assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || out_ready) && !flush;

    // One shift-add step: add the shifted multiplicand when the current
    // multiplier LSB is set.
    always_comb begin
        if (mplier_r[0]) begin
            acc_nxt_s = acc_r + mcand_r;
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // FSM next state and the load strobes. flush outranks everything.
    always_comb begin
        state_nxt_s = state_r;
        load_alu_s  = 1'b0;
        load_mul_s  = 1'b0;
        start_mul_s = 1'b0;
        valid_nxt_s = out_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    valid_nxt_s = 1'b0;
                end else if (accept_s) begin
                    if (is_mul_s) begin
                        start_mul_s = 1'b1;
                        state_nxt_s = ST_MUL;
                        valid_nxt_s = 1'b0;
                    end else begin
                        load_alu_s  = 1'b1;
                        valid_nxt_s = 1'b1;
                    end
                end else if (out_ready) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = out_valid_r;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                    valid_nxt_s = 1'b0;
                end else if (mul_last_s) begin
                    state_nxt_s = ST_IDLE;
                    load_mul_s  = 1'b1;
                    valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_MUL;
                    valid_nxt_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Multiplier datapath. The address and sideband fields are captured at
    // acceptance so that they leave together with the product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r       <= {CNT_W{1'b0}};
            mcand_r     <= ZERO_D;
            mplier_r    <= ZERO_D;
            acc_r       <= ZERO_D;
            pend_dst_r  <= {REG_ADDR_WIDTH{1'b0}};
            pend_addr_r <= ZERO_D;
            pend_data_r <= ZERO_D;
            pend_ctrl_r <= {CTRL_WIDTH{1'b0}};
        end else if (start_mul_s) begin
            cnt_r       <= {CNT_W{1'b0}};
            mcand_r     <= in_data_rs;
            mplier_r    <= op_b_s;
            acc_r       <= ZERO_D;
            pend_dst_r  <= dst_sel_s;
            pend_addr_r <= in_data_rs;
            pend_data_r <= in_data_rt;
            pend_ctrl_r <= in_ctrl;
        end else if (state_r == ST_MUL) begin
            cnt_r    <= cnt_r + CNT_ONE;
            mcand_r  <= {mcand_r[MSB-1:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[MSB:1]};
            acc_r    <= acc_nxt_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end
`else
    assign busy       = 1'b0;
    assign in_ready_s = (!out_valid_r || out_ready) && !flush;

    // Valid sequencing for the single-cycle-only build. flush outranks all.
    always_comb begin
        load_alu_s  = 1'b0;
        valid_nxt_s = out_valid_r;
        if (flush) begin
            valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            load_alu_s  = 1'b1;
            valid_nxt_s = 1'b1;
        end else if (out_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = out_valid_r;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]     alu_out_r;
    logic [5:0]                flags_r;
    logic [REG_ADDR_WIDTH-1:0] reg_dst_r;
    logic [DATA_WIDTH-1:0]     mem_addr_r;
    logic [DATA_WIDTH-1:0]     mem_data_r;
    logic [CTRL_WIDTH-1:0]     out_ctrl_r;

    // Output valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= valid_nxt_s;
        end
    end

    // Result bundle; holds whenever neither path loads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_out_r  <= ZERO_D;
            flags_r    <= 6'b000000;
            reg_dst_r  <= {REG_ADDR_WIDTH{1'b0}};
            mem_addr_r <= ZERO_D;
            mem_data_r <= ZERO_D;
            out_ctrl_r <= {CTRL_WIDTH{1'b0}};
        end else if (load_alu_s) begin
            alu_out_r  <= alu_res_s;
            flags_r    <= make_flags(alu_carry_s, alu_ovf_s, alu_res_s, alu_illegal_s);
            reg_dst_r  <= dst_sel_s;
            mem_addr_r <= in_data_rs;
            mem_data_r <= in_data_rt;
            out_ctrl_r <= in_ctrl;
`ifdef EX_PIPE_MUL_EN
        end else if (load_mul_s) begin
            alu_out_r  <= acc_nxt_s;
            flags_r    <= make_flags(1'b0, 1'b0, acc_nxt_s, 1'b0);
            reg_dst_r  <= pend_dst_r;
            mem_addr_r <= pend_addr_r;
            mem_data_r <= pend_data_r;
            out_ctrl_r <= pend_ctrl_r;
`endif
        end else begin
            alu_out_r <= alu_out_r;
        end
    end

    assign out_valid     = out_valid_r;
    assign alu_out       = alu_out_r;
    assign alu_flags_out = flags_r;
    assign reg_dst       = reg_dst_r;
    assign mem_addr      = mem_addr_r;
    assign mem_data      = mem_data_r;
    assign out_ctrl      = out_ctrl_r;

endmodule

// File: tb/tb_ex_pipe_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_pipe_stage
//
// Directed self-checking bench for ex_pipe_stage with default parameters.
// A reference model computes the expected result for each operation as it is
// driven and queues it. Queued results are compared when the stage presents
// them. Expectations follow EX_PIPE_MUL_EN, as the design does.
// ----------------------------------------------------------------------------
module tb_ex_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alu_funct;
    logic        alu_src_mux;
    logic [1:0]  reg_dst_mux;
    logic [31:0] in_data_rs;
    logic [31:0] in_data_rt;
    logic [31:0] in_immediate;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic [5:0]  alu_flags_out;
    logic [4:0]  reg_dst;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  out_ctrl;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  flags;
        logic [4:0]  dst;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  ctrl;
    } exp_t;

    exp_t sb[$];

    ex_pipe_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_funct     (alu_funct),
        .alu_src_mux   (alu_src_mux),
        .reg_dst_mux   (reg_dst_mux),
        .in_data_rs    (in_data_rs),
        .in_data_rt    (in_data_rt),
        .in_immediate  (in_immediate),
        .in_rt         (in_rt),
        .in_rd         (in_rd),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_out       (alu_out),
        .alu_flags_out (alu_flags_out),
        .reg_dst       (reg_dst),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .out_ctrl      (out_ctrl),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: overflow is detected as "true signed result does not
    // fit", and carry/borrow come from widened arithmetic.
    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b_rt, input logic [31:0] imm,
                                   input logic src, input logic [4:0] rta,
                                   input logic [4:0] rda, input logic [1:0] dm,
                                   input logic [7:0] ctrl);
        exp_t        e;
        logic [31:0] b;
        logic [31:0] r;
        logic [63:0] wide;
        longint      sa;
        longint      sbv;
        longint      sr;
        logic        c;
        logic        v;
        logic        il;
        b   = src ? imm : b_rt;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r = 32'd0; c = 1'b0; v = 1'b0; il = 1'b0;
        case (f)
            6'h00: begin
                wide = {32'd0, a} + {32'd0, b};
                r = wide[31:0]; c = wide[32];
                sr = sa + sbv; v = (sr != longint'($signed(r)));
            end
            6'h01: begin
                r = a - b; c = (a < b);
                sr = sa - sbv; v = (sr != longint'($signed(r)));
            end
            6'h02: r = a & b;
            6'h03: r = a | b;
            6'h04: r = a ^ b;
            6'h05: r = (sa < sbv) ? 32'd1 : 32'd0;
            6'h06: r = b;
`ifdef EX_PIPE_MUL_EN
            6'h10: begin
                wide = {32'd0, a} * {32'd0, b};
                r = wide[31:0];
            end
`endif
            default: il = 1'b1;
        endcase
        e.res   = r;
        e.flags = {c, v, r[31], (r == 32'd0), il, 1'b0};
        case (dm)
            2'd1:    e.dst = rda;
            2'd2:    e.dst = 5'd15;
            default: e.dst = rta;
        endcase
        e.addr = a;
        e.data = b_rt;
        e.ctrl = ctrl;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic src, input logic [4:0] rta,
                         input logic [4:0] rda, input logic [1:0] dm, input logic [7:0] ctrl,
                         input logic push);
        alu_funct = f; in_data_rs = rs; in_data_rt = rt; in_immediate = imm;
        alu_src_mux = src; in_rt = rta; in_rd = rda; reg_dst_mux = dm; in_ctrl = ctrl;
        in_valid = 1'b1;
        if (push) sb.push_back(model(f, rs, rt, imm, src, rta, rda, dm, ctrl));
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".sb"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb[0];
            check({tag, ".res"},   64'(alu_out),       64'(e.res));
            check({tag, ".flags"}, 64'(alu_flags_out), 64'(e.flags));
            check({tag, ".dst"},   64'(reg_dst),       64'(e.dst));
            check({tag, ".addr"},  64'(mem_addr),      64'(e.addr));
            check({tag, ".data"},  64'(mem_data),      64'(e.data));
            check({tag, ".ctrl"},  64'(out_ctrl),      64'(e.ctrl));
        end
    endtask

    task automatic sb_pop();
        if (sb.size() > 0) void'(sb.pop_front());
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(out_valid),     64'd0);
        check({tag, ".busy"},  64'(busy),          64'd0);
        check({tag, ".res"},   64'(alu_out),       64'd0);
        check({tag, ".flags"}, 64'(alu_flags_out), 64'd0);
        check({tag, ".dst"},   64'(reg_dst),       64'd0);
        check({tag, ".addr"},  64'(mem_addr),      64'd0);
        check({tag, ".data"},  64'(mem_data),      64'd0);
        check({tag, ".ctrl"},  64'(out_ctrl),      64'd0);
    endtask

    // Back-to-back operation table
    logic [5:0]  t_f   [0:8] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h05, 6'h06, 6'h00, 6'h01, 6'h3F};
    logic [31:0] t_rs  [0:8] = '{32'hF0F0_1234, 32'h0, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5,
                                 32'h1234_5678, 32'h7FFF_FFFF, 32'h3, 32'h55};
    logic [31:0] t_rt  [0:8] = '{32'h1, 32'h0, 32'hAAAA_5555, 32'h1, 32'hFFFF_FFFD,
                                 32'h9, 32'h1, 32'h5, 32'h66};
    logic [31:0] t_imm [0:8] = '{32'h0FF0_FF00, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h8000_0001, 32'h0, 32'h0, 32'h0};
    logic        t_src [0:8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_funct = 6'h00; alu_src_mux = 1'b0; reg_dst_mux = 2'd0;
        in_data_rs = 32'd0; in_data_rt = 32'd0; in_immediate = 32'd0;
        in_rt = 5'd0; in_rd = 5'd0; in_ctrl = 8'd0;

        // Reset state
        #3;
        check_zero("reset");
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // ADD carry-out with zero result
        out_ready = 1'b1;
        drive(6'h00, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 5'd2, 5'd3, 2'd1, 8'hA5, 1'b1);
        #1 check("add.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_out("add");
        check("add.carry", 64'(alu_flags_out[5]), 64'd1);
        check("add.zero",  64'(alu_flags_out[2]), 64'd1);
        check("add.ovf",   64'(alu_flags_out[4]), 64'd0);
        sb_pop();
        tick();
        check("add.drain", 64'(out_valid), 64'd0);

        // SUB signed overflow, no borrow
        drive(6'h01, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 5'd7, 5'd8, 2'd0, 8'h11, 1'b1);
        tick();
        in_valid = 1'b0;
        check_out("sub");
        check("sub.res",   64'(alu_out),          64'h7FFF_FFFF);
        check("sub.ovf",   64'(alu_flags_out[4]), 64'd1);
        check("sub.carry", 64'(alu_flags_out[5]), 64'd0);
        sb_pop();
        tick();

        // Streaming operations, one per cycle, all destination selects
        for (int i = 0; i < 9; i++) begin
            drive(t_f[i], t_rs[i], t_rt[i], t_imm[i], t_src[i], 5'(i + 1), 5'(i + 20),
                  2'(i % 4), 8'(i * 17), 1'b1);
            #1 check($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'd1);
            tick();
            check_out($sformatf("stream%0d", i));
            sb_pop();
        end
        in_valid = 1'b0;
        tick();
        check("stream.drain", 64'(out_valid), 64'd0);

        // Backpressure: second op held off, first result stable, no bubble
        out_ready = 1'b0;
        drive(6'h00, 32'd100, 32'd23, 32'h0, 1'b0, 5'd4, 5'd5, 2'd0, 8'h21, 1'b1);
        tick();
        check_out("bp.first");
        drive(6'h00, 32'd7, 32'd8, 32'h0, 1'b0, 5'd9, 5'd10, 2'd1, 8'h22, 1'b1);
        #1 check("bp.held_ready", 64'(in_ready), 64'd0);
        repeat (2) begin
            tick();
            check_out("bp.stable");
            check("bp.still_held", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1 check("bp.release_ready", 64'(in_ready), 64'd1);
        sb_pop();
        tick();
        in_valid = 1'b0;
        check_out("bp.second");
        sb_pop();
        tick();
        check("bp.drain", 64'(out_valid), 64'd0);

        // MUL 7 x 6
        drive(6'h10, 32'd7, 32'd6, 32'h0, 1'b0, 5'd3, 5'd4, 2'd2, 8'h3C, 1'b1);
        #1 check("mul.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
`ifdef EX_PIPE_MUL_EN
        for (int k = 0; k < 32; k++) begin
            check($sformatf("mul.busy%0d", k),  64'(busy),      64'd1);
            check($sformatf("mul.ready%0d", k), 64'(in_ready),  64'd0);
            check($sformatf("mul.valid%0d", k), 64'(out_valid), 64'd0);
            tick();
        end
        check("mul.res42", 64'(alu_out), 64'd42);
`else
        check("mul.illegal", 64'(alu_flags_out[1]), 64'd1);
`endif
        check("mul.busy_done", 64'(busy), 64'd0);
        check_out("mul");
        sb_pop();
        tick();
        check("mul.drain", 64'(out_valid), 64'd0);

        // flush kills a held result and blocks a simultaneous offer
        out_ready = 1'b0;
        drive(6'h03, 32'h0F, 32'hF0, 32'h0, 1'b0, 5'd1, 5'd2, 2'd0, 8'h44, 1'b1);
        tick();
        check_out("flush.held");
        drive(6'h00, 32'd1, 32'd1, 32'h0, 1'b0, 5'd1, 5'd2, 2'd0, 8'h45, 1'b0);
        flush = 1'b1;
        #1 check("flush.in_ready", 64'(in_ready), 64'd0);
        tick();
        check("flush.valid", 64'(out_valid), 64'd0);
        sb_pop();
        flush = 1'b0;
        in_valid = 1'b0;
        #1 check("flush.ready_after", 64'(in_ready), 64'd1);
        tick();
        check("flush.no_accept", 64'(out_valid), 64'd0);

`ifdef EX_PIPE_MUL_EN
        // flush during MUL iteration 10
        out_ready = 1'b1;
        drive(6'h10, 32'd9, 32'd9, 32'h0, 1'b0, 5'd1, 5'd2, 2'd0, 8'h55, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("mflush.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        check("mflush.busy", 64'(busy), 64'd0);
        check("mflush.valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        #1 check("mflush.ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("mflush.quiet%0d", k), 64'(out_valid), 64'd0);
        end

        // Reset mid-MUL with a link-register destination pending
        drive(6'h10, 32'd3, 32'd5, 32'h0, 1'b0, 5'd1, 5'd2, 2'd2, 8'h66, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("rmul.busy_before", 64'(busy), 64'd1);
`else
        // Reset while a link-register result is held
        drive(6'h00, 32'd3, 32'd5, 32'h0, 1'b0, 5'd1, 5'd2, 2'd2, 8'h66, 1'b1);
        tick();
        in_valid = 1'b0;
        check_out("rhold");
`endif
        rst = 1'b0;
        #1 check_zero("rmid");
        sb.delete();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check($sformatf("rpost.valid%0d", k), 64'(out_valid), 64'd0);
            check($sformatf("rpost.dst%0d", k),   64'(reg_dst),   64'd0);
        end

        check("sb.empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
